// File: rtl/pci_io_gen2.sv
// PCI target I/O layer: bus sampling, AD/PAR drivers, parity checking with PERR#
// signalling and an error counter, and the TRDY#/STOP#/DEVSEL# drive/park sequencer.
module pci_io_gen2 #(
  parameter int DW   = 32,
  parameter int ERRW = 8
) (
  input  logic              pci_clk,
  input  logic              pci_rst,
  // PCI pads
  input  logic [DW-1:0]     pci_adi,
  output logic [DW-1:0]     pci_ado,
  output logic              pci_ado_ot,
  output logic              pci_paro_ot,
  input  logic [DW/8-1:0]   pci_cbei,
  input  logic [DW/32-1:0]  pci_pari,
  output logic [DW/32-1:0]  pci_paro,
  input  logic              pci_frame_ni,
  input  logic              pci_irdy_ni,
  input  logic              pci_idseli,
  output logic              pci_trdy_no,
  output logic              pci_stop_no,
  output logic              pci_devsel_no,
  output logic              pci_tsd_ot,
  output logic              pci_perr_no,
  output logic              pci_perr_ot,
  output logic              pci_serr_ot,
  output logic              pci_inta_ot,
  // registered and pass-through bus samples for the core
  output logic [DW-1:0]     adi,
  output logic [DW/8-1:0]   cbeid,
  output logic              framenid,
  output logic              irdynid,
  output logic              idselid,
  output logic              trdynid,
  output logic              frameni,
  output logic              irdyni,
  // core side
  input  logic [DW-1:0]     ado,
  input  logic [DW-1:0]     cfg_ado,
  input  logic              ce_adodir,
  input  logic              ce_adordy,
  input  logic              drv_ad,
  input  logic              drv_tsd,
  input  logic              new_trdyno,
  input  logic              new_stopno,
  input  logic              new_devselno,
  input  logic              new_serrno,
  input  logic              intano,
  input  logic              par_chk_en,
  input  logic              perr_resp,
  input  logic              perr_cnt_clr,
  output logic [ERRW-1:0]   perr_cnt,
  output logic              perr_pulse
);

  localparam int NL = DW / 32;
  localparam logic [ERRW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {PERR_IDLE, PERR_ASSERT, PERR_PARK} perr_state_e;
  typedef enum logic [1:0] {TSD_REL, TSD_DRV, TSD_PARK} tsd_state_e;

  perr_state_e     perr_q, perr_d;
  tsd_state_e      tsd_q, tsd_d;
  logic            chk_q;
  logic            ce_ado;
  logic [NL-1:0]   par_d;
  logic [NL-1:0]   err_lane;
  logic            err;
  logic [ERRW-1:0] cnt_d;

  assign frameni = pci_frame_ni;
  assign irdyni  = pci_irdy_ni;

  // NOTE: every clocked register uses <= so all flops sample pre-edge values
  // together; a blocking = here would let later statements see updated values.
  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      adi      <= '0;
      cbeid    <= '0;
      idselid  <= 1'b0;
      framenid <= 1'b1;
      irdynid  <= 1'b1;
      trdynid  <= 1'b1;
    end else begin
      adi      <= pci_adi;
      cbeid    <= pci_cbei;
      idselid  <= pci_idseli;
      framenid <= pci_frame_ni;
      irdynid  <= pci_irdy_ni;
      trdynid  <= pci_trdy_no;
    end
  end

  // Read data advances on a direct load, or on a ready load once the master accepts it.
  assign ce_ado = ce_adodir | (ce_adordy & ~pci_irdy_ni);

  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      pci_ado <= '0;
    end else if (ce_ado) begin
      pci_ado <= ado | cfg_ado;
    end
  end

  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      pci_ado_ot  <= 1'b1;
      pci_paro_ot <= 1'b1;
      pci_serr_ot <= 1'b1;
      pci_inta_ot <= 1'b1;
    end else begin
      pci_ado_ot  <= ~drv_ad;
      pci_paro_ot <= pci_ado_ot;
      pci_serr_ot <= new_serrno;
      pci_inta_ot <= intano;
    end
  end

  // NOTE: combinational blocks assign defaults before any branch so that no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    par_d    = '0;
    err_lane = '0;
    for (int i = 0; i < NL; i++) begin
      par_d[i]    = (^pci_ado[32*i +: 32]) ^ (^pci_cbei[4*i +: 4]);
      err_lane[i] = chk_q & (((^adi[32*i +: 32]) ^ (^cbeid[4*i +: 4])) != pci_pari[i]);
    end
    err = |err_lane;
  end

  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      pci_paro   <= '0;
      chk_q      <= 1'b0;
      perr_pulse <= 1'b0;
    end else begin
      pci_paro   <= par_d;
      chk_q      <= par_chk_en;
      perr_pulse <= err;
    end
  end

  // Clear wins over increment but still counts an error arriving on the same edge.
  always_comb begin
    cnt_d = perr_cnt;
    if (perr_cnt_clr) begin
      cnt_d = err ? ERRW'(1) : '0;
    end else if (err && (perr_cnt != CNT_MAX)) begin
      cnt_d = perr_cnt + ERRW'(1);
    end
  end

  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      perr_cnt <= '0;
    end else begin
      perr_cnt <= cnt_d;
    end
  end

  always_comb begin
    perr_d = perr_q;
    case (perr_q)
      PERR_ASSERT: perr_d = PERR_PARK;
      PERR_PARK:   perr_d = PERR_IDLE;
      default:     perr_d = PERR_IDLE;
    endcase
    if (err && perr_resp) begin
      perr_d = PERR_ASSERT;
    end
  end

  // Pad drives are registered from the next state so they change glitch-free on the edge.
  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      perr_q      <= PERR_IDLE;
      pci_perr_no <= 1'b1;
      pci_perr_ot <= 1'b1;
    end else begin
      perr_q      <= perr_d;
      pci_perr_no <= (perr_d != PERR_ASSERT);
      pci_perr_ot <= (perr_d == PERR_IDLE);
    end
  end

  always_comb begin
    tsd_d = tsd_q;
    case (tsd_q)
      TSD_DRV:  tsd_d = TSD_PARK;
      TSD_PARK: tsd_d = TSD_REL;
      default:  tsd_d = TSD_REL;
    endcase
    if (drv_tsd) begin
      tsd_d = TSD_DRV;
    end
  end

  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      tsd_q         <= TSD_REL;
      pci_tsd_ot    <= 1'b1;
      pci_trdy_no   <= 1'b1;
      pci_stop_no   <= 1'b1;
      pci_devsel_no <= 1'b1;
    end else begin
      tsd_q         <= tsd_d;
      pci_tsd_ot    <= (tsd_d == TSD_REL);
      pci_trdy_no   <= (tsd_d == TSD_DRV) ? new_trdyno   : 1'b1;
      pci_stop_no   <= (tsd_d == TSD_DRV) ? new_stopno   : 1'b1;
      pci_devsel_no <= (tsd_d == TSD_DRV) ? new_devselno : 1'b1;
    end
  end

endmodule

// File: tb/tb_pci_io_gen2.sv
// Directed bench: a 32-bit/8-bit-counter instance and a 64-bit/2-bit-counter instance
// share one stimulus set; the narrow one sees the low lane only.
module tb_pci_io_gen2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pci_adi, ado, cfg_ado;
  logic [7:0]  cbei;
  logic [1:0]  pari;
  logic frame_n, irdy_n, idsel, ce_dir, ce_rdy, drv_ad, drv_tsd;
  logic new_trdyno, new_stopno, new_devselno, new_serrno, intano;
  logic par_chk_en, perr_resp, perr_cnt_clr;

  logic [63:0] o64_ado, o64_adi;
  logic [7:0]  o64_cbeid;
  logic [1:0]  o64_paro;
  logic [1:0]  o64_cnt;
  logic o64_ado_ot, o64_paro_ot, o64_trdy, o64_stop, o64_devsel, o64_tsd_ot;
  logic o64_perr_no, o64_perr_ot, o64_serr_ot, o64_inta_ot;
  logic o64_framenid, o64_irdynid, o64_idselid, o64_trdynid, o64_frameni, o64_irdyni, o64_pulse;

  logic [31:0] o32_ado, o32_adi;
  logic [3:0]  o32_cbeid;
  logic [0:0]  o32_paro;
  logic [7:0]  o32_cnt;
  logic o32_ado_ot, o32_paro_ot, o32_trdy, o32_stop, o32_devsel, o32_tsd_ot;
  logic o32_perr_no, o32_perr_ot, o32_serr_ot, o32_inta_ot;
  logic o32_framenid, o32_irdynid, o32_idselid, o32_trdynid, o32_frameni, o32_irdyni, o32_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  pci_io_gen2 #(.DW(64), .ERRW(2)) dut64 (
    .pci_clk(clk), .pci_rst(rst),
    .pci_adi(pci_adi), .pci_ado(o64_ado), .pci_ado_ot(o64_ado_ot), .pci_paro_ot(o64_paro_ot),
    .pci_cbei(cbei), .pci_pari(pari), .pci_paro(o64_paro),
    .pci_frame_ni(frame_n), .pci_irdy_ni(irdy_n), .pci_idseli(idsel),
    .pci_trdy_no(o64_trdy), .pci_stop_no(o64_stop), .pci_devsel_no(o64_devsel),
    .pci_tsd_ot(o64_tsd_ot), .pci_perr_no(o64_perr_no), .pci_perr_ot(o64_perr_ot),
    .pci_serr_ot(o64_serr_ot), .pci_inta_ot(o64_inta_ot),
    .adi(o64_adi), .cbeid(o64_cbeid), .framenid(o64_framenid), .irdynid(o64_irdynid),
    .idselid(o64_idselid), .trdynid(o64_trdynid), .frameni(o64_frameni), .irdyni(o64_irdyni),
    .ado(ado), .cfg_ado(cfg_ado), .ce_adodir(ce_dir), .ce_adordy(ce_rdy),
    .drv_ad(drv_ad), .drv_tsd(drv_tsd), .new_trdyno(new_trdyno), .new_stopno(new_stopno),
    .new_devselno(new_devselno), .new_serrno(new_serrno), .intano(intano),
    .par_chk_en(par_chk_en), .perr_resp(perr_resp), .perr_cnt_clr(perr_cnt_clr),
    .perr_cnt(o64_cnt), .perr_pulse(o64_pulse)
  );

  pci_io_gen2 dut32 (
    .pci_clk(clk), .pci_rst(rst),
    .pci_adi(pci_adi[31:0]), .pci_ado(o32_ado), .pci_ado_ot(o32_ado_ot), .pci_paro_ot(o32_paro_ot),
    .pci_cbei(cbei[3:0]), .pci_pari(pari[0:0]), .pci_paro(o32_paro),
    .pci_frame_ni(frame_n), .pci_irdy_ni(irdy_n), .pci_idseli(idsel),
    .pci_trdy_no(o32_trdy), .pci_stop_no(o32_stop), .pci_devsel_no(o32_devsel),
    .pci_tsd_ot(o32_tsd_ot), .pci_perr_no(o32_perr_no), .pci_perr_ot(o32_perr_ot),
    .pci_serr_ot(o32_serr_ot), .pci_inta_ot(o32_inta_ot),
    .adi(o32_adi), .cbeid(o32_cbeid), .framenid(o32_framenid), .irdynid(o32_irdynid),
    .idselid(o32_idselid), .trdynid(o32_trdynid), .frameni(o32_frameni), .irdyni(o32_irdyni),
    .ado(ado[31:0]), .cfg_ado(cfg_ado[31:0]), .ce_adodir(ce_dir), .ce_adordy(ce_rdy),
    .drv_ad(drv_ad), .drv_tsd(drv_tsd), .new_trdyno(new_trdyno), .new_stopno(new_stopno),
    .new_devselno(new_devselno), .new_serrno(new_serrno), .intano(intano),
    .par_chk_en(par_chk_en), .perr_resp(perr_resp), .perr_cnt_clr(perr_cnt_clr),
    .perr_cnt(o32_cnt), .perr_pulse(o32_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [63:0] adi;
    logic [7:0]  cbe;
    logic        frame_n, irdy_n, idsel;
    logic [63:0] ado, cfg;
    logic        ce_dir, ce_rdy, drv_ad, serrno, intano;
    logic [63:0] e_ado;
    logic        e_ado_ot, e_serr_ot, e_inta_ot;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // rst adi cbe frame irdy idsel ado cfg ce_dir ce_rdy drv serr inta | e_ado e_ot e_serr e_inta
    vecs[0] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA,
                64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 64'h0000_0001_1234_5678, 8'hA5, 1'b0, 1'b1, 1'b1, 64'hCAFE_0000_1234_5678,
                64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'hCAFE_0000_1234_5678, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 64'h8000_0000_0000_0003, 8'h3C, 1'b1, 1'b1, 1'b0, 64'h0000_000F_0000_000F,
                64'h0000_00F0_0000_00F0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'hCAFE_0000_1234_5678,
                1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 64'h5555_AAAA_0F0F_F0F0, 8'h81, 1'b1, 1'b0, 1'b1, 64'h0000_000F_0000_000F,
                64'h0F00_00F0_A500_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0F00_00FF_A500_000F,
                1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0F00_00FF_A500_000F, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 64'h0123_4567_89AB_CDEF, 8'h5A, 1'b1, 1'b0, 1'b1, 64'h0,
                64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0001,
                1'b0, 1'b1, 1'b1};

    // Reset with hostile inputs: every output must land on its reset value.
    rst = 1'b1; pci_adi = '1; ado = '1; cfg_ado = '1; cbei = '1; pari = '1;
    frame_n = 1'b0; irdy_n = 1'b0; idsel = 1'b1; ce_dir = 1'b1; ce_rdy = 1'b1;
    drv_ad = 1'b1; drv_tsd = 1'b1; new_trdyno = 1'b0; new_stopno = 1'b0; new_devselno = 1'b0;
    new_serrno = 1'b0; intano = 1'b0; par_chk_en = 1'b1; perr_resp = 1'b1; perr_cnt_clr = 1'b0;
    #2;
    tick();
    tick();
    check("rst_ado64", o64_ado, 64'h0);
    check("rst_ado32", {32'h0, o32_ado}, 64'h0);
    check("rst_oes64", {o64_ado_ot, o64_paro_ot, o64_tsd_ot, o64_perr_ot, o64_serr_ot, o64_inta_ot}, 64'h3F);
    check("rst_oes32", {o32_ado_ot, o32_paro_ot, o32_tsd_ot, o32_perr_ot, o32_serr_ot, o32_inta_ot}, 64'h3F);
    check("rst_ctl64", {o64_trdy, o64_stop, o64_devsel, o64_perr_no, o64_framenid, o64_irdynid, o64_trdynid}, 64'h7F);
    check("rst_ctl32", {o32_trdy, o32_stop, o32_devsel, o32_perr_no, o32_framenid, o32_irdynid, o32_trdynid}, 64'h7F);
    check("rst_zero64", {o64_paro, o64_adi != 0, o64_cbeid, o64_idselid, o64_cnt, o64_pulse}, 64'h0);
    check("rst_zero32", {o32_paro, o32_adi != 0, o32_cbeid, o32_idselid, o32_cnt, o32_pulse}, 64'h0);

    drv_tsd = 1'b0; par_chk_en = 1'b0; perr_resp = 1'b0; pari = '0;
    new_trdyno = 1'b1; new_stopno = 1'b1; new_devselno = 1'b1;

    // Table: one registered cycle per row.
    for (int r = 0; r < 6; r++) begin
      rst = vecs[r].rst; pci_adi = vecs[r].adi; cbei = vecs[r].cbe;
      frame_n = vecs[r].frame_n; irdy_n = vecs[r].irdy_n; idsel = vecs[r].idsel;
      ado = vecs[r].ado; cfg_ado = vecs[r].cfg; ce_dir = vecs[r].ce_dir; ce_rdy = vecs[r].ce_rdy;
      drv_ad = vecs[r].drv_ad; new_serrno = vecs[r].serrno; intano = vecs[r].intano;
      #1;
      check($sformatf("v%0d_passthru64", r), {o64_frameni, o64_irdyni}, {frame_n, irdy_n});
      check($sformatf("v%0d_passthru32", r), {o32_frameni, o32_irdyni}, {frame_n, irdy_n});
      tick();
      check($sformatf("v%0d_adi64", r), o64_adi, vecs[r].rst ? 64'h0 : vecs[r].adi);
      check($sformatf("v%0d_adi32", r), {32'h0, o32_adi}, vecs[r].rst ? 64'h0 : {32'h0, vecs[r].adi[31:0]});
      check($sformatf("v%0d_cbeid64", r), {56'h0, o64_cbeid}, vecs[r].rst ? 64'h0 : {56'h0, vecs[r].cbe});
      check($sformatf("v%0d_cbeid32", r), {60'h0, o32_cbeid}, vecs[r].rst ? 64'h0 : {60'h0, vecs[r].cbe[3:0]});
      check($sformatf("v%0d_samp64", r), {o64_idselid, o64_framenid, o64_irdynid},
            vecs[r].rst ? 64'h3 : {61'h0, vecs[r].idsel, vecs[r].frame_n, vecs[r].irdy_n});
      check($sformatf("v%0d_samp32", r), {o32_idselid, o32_framenid, o32_irdynid},
            vecs[r].rst ? 64'h3 : {61'h0, vecs[r].idsel, vecs[r].frame_n, vecs[r].irdy_n});
      check($sformatf("v%0d_ado64", r), o64_ado, vecs[r].e_ado);
      check($sformatf("v%0d_ado32", r), {32'h0, o32_ado}, {32'h0, vecs[r].e_ado[31:0]});
      check($sformatf("v%0d_oes64", r), {o64_ado_ot, o64_serr_ot, o64_inta_ot},
            {61'h0, vecs[r].e_ado_ot, vecs[r].e_serr_ot, vecs[r].e_inta_ot});
      check($sformatf("v%0d_oes32", r), {o32_ado_ot, o32_serr_ot, o32_inta_ot},
            {61'h0, vecs[r].e_ado_ot, vecs[r].e_serr_ot, vecs[r].e_inta_ot});
    end

    // Parity generation: load 0x12345678 (lane 1: 0x3), then PAR one cycle later.
    ce_dir = 1'b1; ce_rdy = 1'b0; ado = 64'h0000_0003_1234_5678; cfg_ado = '0; cbei = 8'h00; drv_ad = 1'b0;
    tick();
    check("par_load64", o64_ado, 64'h0000_0003_1234_5678);
    check("par_load32", {32'h0, o32_ado}, 64'h1234_5678);
    ce_dir = 1'b0; cbei = 8'h10;
    tick();
    check("par_a64", {62'h0, o64_paro}, 64'h3);
    check("par_a32", {63'h0, o32_paro}, 64'h1);
    cbei = 8'h01;
    tick();
    check("par_b64", {62'h0, o64_paro}, 64'h0);
    check("par_b32", {63'h0, o32_paro}, 64'h0);

    // AD enable for 3 cycles; PAR enable trails by one.
    begin
      logic [4:0] e_ad_ot, e_par_ot;
      e_ad_ot = 5'b11000; e_par_ot = 5'b10001;
      for (int i = 0; i < 5; i++) begin
        drv_ad = (i < 3);
        tick();
        check($sformatf("oe%0d_ado_ot", i), {o64_ado_ot, o32_ado_ot}, {2{e_ad_ot[i]}});
        check($sformatf("oe%0d_paro_ot", i), {o64_paro_ot, o32_paro_ot}, {2{e_par_ot[i]}});
      end
    end

    // Lane-0 parity error with PERR# response enabled.
    pci_adi = 64'h1; cbei = 8'h00; pari = 2'b00; par_chk_en = 1'b1; perr_resp = 1'b1;
    tick();
    par_chk_en = 1'b0; pci_adi = '0;
    tick();
    check("perr_pulse", {o64_pulse, o32_pulse}, 64'h3);
    check("perr_assert64", {o64_perr_ot, o64_perr_no}, 64'h0);
    check("perr_assert32", {o32_perr_ot, o32_perr_no}, 64'h0);
    tick();
    check("perr_pulse_end", {o64_pulse, o32_pulse}, 64'h0);
    check("perr_park", {o64_perr_ot, o64_perr_no, o32_perr_ot, o32_perr_no}, 64'h5);
    tick();
    check("perr_idle", {o64_perr_ot, o64_perr_no, o32_perr_ot, o32_perr_no}, 64'hF);
    check("perr_cnt1", {o64_cnt, o32_cnt}, {2'd1, 8'd1});

    // Lane-1-only error, PERR# response disabled.
    pci_adi = 64'h0000_0001_0000_0000; par_chk_en = 1'b1; perr_resp = 1'b0;
    tick();
    par_chk_en = 1'b0; pci_adi = '0;
    tick();
    check("lane1_pulse", {o64_pulse, o32_pulse}, 64'h2);
    check("lane1_cnt", {o64_cnt, o32_cnt}, {2'd2, 8'd1});
    check("lane1_perr64", {o64_perr_ot, o64_perr_no}, 64'h3);
    tick();
    check("lane1_perr64_after", {o64_perr_ot, o64_perr_no}, 64'h3);

    // Counter saturation (2-bit instance) and clear-with-error.
    perr_cnt_clr = 1'b1;
    tick();
    check("cnt_clr", {o64_cnt, o32_cnt}, 64'h0);
    perr_cnt_clr = 1'b0; pci_adi = 64'h1; par_chk_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("sat%0d_cnt64", k), {62'h0, o64_cnt}, (k - 1 > 3) ? 64'd3 : 64'(k - 1));
      check($sformatf("sat%0d_cnt32", k), {56'h0, o32_cnt}, 64'(k - 1));
    end
    check("sat_perr_ot", {o64_perr_ot, o32_perr_ot}, 64'h3);
    perr_cnt_clr = 1'b1;
    tick();
    check("clr_with_err", {o64_cnt, o32_cnt}, {2'd1, 8'd1});
    perr_cnt_clr = 1'b0; par_chk_en = 1'b0; pci_adi = '0;
    tick();
    tick();

    // Back-to-back responded errors hold PERR# asserted.
    pci_adi = 64'h1; par_chk_en = 1'b1; perr_resp = 1'b1;
    tick();
    tick();
    par_chk_en = 1'b0; pci_adi = '0;
    check("b2b_first", {o64_perr_ot, o64_perr_no}, 64'h0);
    tick();
    check("b2b_second", {o64_perr_ot, o64_perr_no}, 64'h0);
    tick();
    check("b2b_park", {o64_perr_ot, o64_perr_no}, 64'h1);
    tick();
    check("b2b_idle", {o64_perr_ot, o64_perr_no}, 64'h3);
    perr_resp = 1'b0;

    // TRDY#/STOP#/DEVSEL# drive for 2 cycles, park 1, release.
    new_trdyno = 1'b0; new_stopno = 1'b1; new_devselno = 1'b0; drv_tsd = 1'b1;
    tick();
    check("tsd_drv1", {o64_tsd_ot, o64_trdy, o64_stop, o64_devsel}, 64'b0010);
    check("tsd_drv1_32", {o32_tsd_ot, o32_trdy, o32_stop, o32_devsel}, 64'b0010);
    tick();
    check("tsd_drv2", {o64_tsd_ot, o64_trdy, o64_stop, o64_devsel}, 64'b0010);
    check("tsd_trdynid2", {o64_trdynid, o32_trdynid}, 64'h0);
    drv_tsd = 1'b0;
    tick();
    check("tsd_park", {o64_tsd_ot, o64_trdy, o64_stop, o64_devsel}, 64'b0111);
    check("tsd_park32", {o32_tsd_ot, o32_trdy, o32_stop, o32_devsel}, 64'b0111);
    check("tsd_trdynid3", {o64_trdynid, o32_trdynid}, 64'h0);
    tick();
    check("tsd_rel", {o64_tsd_ot, o64_trdy, o64_stop, o64_devsel}, 64'b1111);
    check("tsd_trdynid4", {o64_trdynid, o32_trdynid}, 64'h3);

    // Reset mid-transaction releases all drivers immediately, with no park cycle.
    drv_tsd = 1'b1; drv_ad = 1'b1;
    tick();
    check("mid_drv", {o64_tsd_ot, o64_ado_ot}, 64'h0);
    rst = 1'b1;
    tick();
    check("mid_rst64", {o64_tsd_ot, o64_trdy, o64_stop, o64_devsel, o64_ado_ot, o64_paro_ot}, 64'h3F);
    check("mid_rst32", {o32_tsd_ot, o32_trdy, o32_stop, o32_devsel, o32_ado_ot, o32_paro_ot}, 64'h3F);
    rst = 1'b0; drv_tsd = 1'b0; drv_ad = 1'b0;
    tick();
    check("mid_no_park", {o64_tsd_ot, o32_tsd_ot}, 64'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
